mont_redc_serial: RTL

- Bit-serial Montgomery reduction (REDC) unit that consumes the 2W-bit product emitted by the Karatsuba multiplier stage.
- Returns r = t·2^(-W) mod N, bringing products back into the Montgomery domain.
- Sits directly downstream of the multiplier in the modular-multiplication datapath.
- Uses a valid/ready handshake on both sides and processes one operand at a time.

---
 rtl/mont_redc_serial.sv | 101 ++++++++++
 1 files changed

// File: rtl/mont_redc_serial.sv
// Bit-serial Montgomery reduction: r = t * 2^(-W) mod n, one bit of t retired per cycle.
// Accepts one 2W-bit product at a time from the upstream multiplier over a valid/ready handshake.
module mont_redc_serial #(
    parameter int W  = 130,
    parameter int CW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] t,
    input  logic [W-1:0]   n,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   r,
    output logic           out_err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINAL,
        HOLD
    } state_t;

    state_t        state;
    logic [2*W:0]  acc;
    logic [W-1:0]  nreg;
    logic [CW-1:0] cnt;
    logic          err_l;

    logic [2*W:0]  acc_sum;
    logic [2*W:0]  acc_next;
    logic          acc_geq_n;
    logic [W-1:0]  acc_sub_n;

    // One REDC step: make acc even by adding n when needed, then halve.
    // The sum is kept at full 2W+1 width so the carry out of the top is never lost.
    always_comb begin
        acc_sum  = acc + (acc[0] ? {{(W+1){1'b0}}, nreg} : '0);
        acc_next = acc_sum >> 1;
    end

    // After W steps acc < 2n, so only bits [W:0] matter and one subtraction suffices.
    // The W-bit difference is exact whenever acc >= n because the result is below n.
    always_comb begin
        acc_geq_n = acc[W:0] >= {1'b0, nreg};
        acc_sub_n = acc[W-1:0] - nreg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            r         <= '0;
            acc       <= '0;
            nreg      <= '0;
            cnt       <= '0;
            err_l     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc      <= {1'b0, t};
                        nreg     <= n;
                        cnt      <= '0;
                        err_l    <= ~n[0] | (t[2*W-1:W] >= n);
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    r         <= acc_geq_n ? acc_sub_n : acc[W-1:0];
                    out_err   <= err_l;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
